// File: rtl/core_wb_arbiter_pkg.sv
// core_wb_arbiter_pkg
//   Shared widths and FSM state encodings for the register-file write-port
//   arbiter. The width and state-encoding macros normally come from the
//   core's defines; fallback definitions are provided here so the slice
//   builds on its own.
//   No ports (package only).

`ifndef CPU_RFIDX_WIDTH
`define CPU_RFIDX_WIDTH 5
`endif
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif
`ifndef WBARB_EMPTY
`define WBARB_EMPTY 2'd0
`endif
`ifndef WBARB_WAIT
`define WBARB_WAIT 2'd1
`endif
`ifndef WBARB_DRAIN
`define WBARB_DRAIN 2'd2
`endif

package core_wb_arbiter_pkg;

    localparam int RFIDX_W = `CPU_RFIDX_WIDTH;
    localparam int OPND_W  = `OPERAND_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = `WBARB_EMPTY,
        ST_WAIT  = `WBARB_WAIT,
        ST_DRAIN = `WBARB_DRAIN
    } wbarb_state_e;

endpackage

// File: rtl/core_wb_arbiter_hold_buf.sv
// wb_hold_buf
//   One-entry register that parks a mul/div result which lost the write
//   port to the WB stage.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (clears valid)
//     load            capture idx_i/data_i and mark the entry valid
//     clear           invalidate the entry (retired or superseded)
//     idx_i, data_i   result to capture
//     valid_o         entry occupied
//     idx_o, data_o   held destination index and data

module wb_hold_buf
    import core_wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [RFIDX_W-1:0] idx_i,
    input  logic [OPND_W-1:0]  data_i,
    output logic               valid_o,
    output logic [RFIDX_W-1:0] idx_o,
    output logic [OPND_W-1:0]  data_o
);

    logic               valid_d, valid_q;
    logic [RFIDX_W-1:0] idx_d, idx_q;
    logic [OPND_W-1:0]  data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = idx_i;
            data_d  = data_i;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // Only the valid bit needs reset; payload is meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;

endmodule

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter
//   Shares the single integer register-file write port between the in-order
//   WB stage and the mul/div completion path. A mul/div result that collides
//   with a pipeline write is parked in a one-entry hold buffer and retired in
//   the next free slot; after MAX_WAIT busy cycles WB is stalled for exactly
//   one cycle to force it out.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     pipe_wen_i/idx_i/data_i         WB stage write request (zero latency)
//     md_valid_i/idx_i/data_i         mul/div result, taken on valid&&ready
//     md_ready_o                      arbiter can accept a mul/div result
//     pipe_stall_o                    WB write suppressed; WB must hold
//     rf_wen_o/idx_o/data_o           register-file write port
//     hold_valid_o/hold_idx_o         hold buffer status for decode hazards

module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_wen_i,
    input  logic [RFIDX_W-1:0] pipe_idx_i,
    input  logic [OPND_W-1:0]  pipe_data_i,
    input  logic               md_valid_i,
    input  logic [RFIDX_W-1:0] md_idx_i,
    input  logic [OPND_W-1:0]  md_data_i,
    output logic               md_ready_o,
    output logic               pipe_stall_o,
    output logic               rf_wen_o,
    output logic [RFIDX_W-1:0] rf_idx_o,
    output logic [OPND_W-1:0]  rf_data_o,
    output logic               hold_valid_o,
    output logic [RFIDX_W-1:0] hold_idx_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    wbarb_state_e       state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    logic               hb_load, hb_clear, hb_valid;
    logic [RFIDX_W-1:0] hb_idx;
    logic [OPND_W-1:0]  hb_data;

    logic               slot_busy;
    logic               md_ready, stall, wen;
    logic [RFIDX_W-1:0] wr_idx;
    logic [OPND_W-1:0]  wr_data;

    // x0 writes are architecturally dead, so they never occupy the port.
    assign slot_busy = pipe_wen_i && (pipe_idx_i != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hb_load  = 1'b0;
        hb_clear = 1'b0;
        md_ready = 1'b0;
        stall    = 1'b0;
        wen      = slot_busy;
        wr_idx   = pipe_idx_i;
        wr_data  = pipe_data_i;

        unique case (state_q)
            ST_EMPTY: begin
                md_ready = 1'b1;
                if (md_valid_i && (md_idx_i != '0)) begin
                    if (!slot_busy) begin
                        wen     = 1'b1;
                        wr_idx  = md_idx_i;
                        wr_data = md_data_i;
                    end else if (pipe_idx_i != md_idx_i) begin
                        // Same-index collision drops md: WB is younger.
                        hb_load = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (slot_busy && (pipe_idx_i == hb_idx)) begin
                    hb_clear = 1'b1;
                    state_d  = ST_EMPTY;
                end else if (!slot_busy) begin
                    wen      = 1'b1;
                    wr_idx   = hb_idx;
                    wr_data  = hb_data;
                    hb_clear = 1'b1;
                    state_d  = ST_EMPTY;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                stall    = 1'b1;
                wen      = 1'b1;
                wr_idx   = hb_idx;
                wr_data  = hb_data;
                hb_clear = 1'b1;
                state_d  = ST_EMPTY;
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (rst) begin
            hb_load  = 1'b0;
            hb_clear = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    wb_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (hb_load),
        .clear   (hb_clear),
        .idx_i   (md_idx_i),
        .data_i  (md_data_i),
        .valid_o (hb_valid),
        .idx_o   (hb_idx),
        .data_o  (hb_data)
    );

    // Every output is forced quiet while reset is held.
    always_comb begin
        md_ready_o   = 1'b0;
        pipe_stall_o = 1'b0;
        rf_wen_o     = 1'b0;
        rf_idx_o     = '0;
        rf_data_o    = '0;
        hold_valid_o = 1'b0;
        hold_idx_o   = '0;
        if (!rst) begin
            md_ready_o   = md_ready;
            pipe_stall_o = stall;
            rf_wen_o     = wen;
            rf_idx_o     = wr_idx;
            rf_data_o    = wr_data;
            hold_valid_o = hb_valid;
            hold_idx_o   = hb_idx;
        end
    end

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;
    import core_wb_arbiter_pkg::*;

    localparam int IW = RFIDX_W;
    localparam int DW = OPND_W;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_wen_i;
    logic [IW-1:0] pipe_idx_i;
    logic [DW-1:0] pipe_data_i;
    logic          md_valid_i;
    logic [IW-1:0] md_idx_i;
    logic [DW-1:0] md_data_i;
    logic          md_ready_o, pipe_stall_o, rf_wen_o, hold_valid_o;
    logic [IW-1:0] rf_idx_o, hold_idx_o;
    logic [DW-1:0] rf_data_o;

    always #5 clk = ~clk;

    core_wb_arbiter #(.MAX_WAIT(MW), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wen_i   (pipe_wen_i),
        .pipe_idx_i   (pipe_idx_i),
        .pipe_data_i  (pipe_data_i),
        .md_valid_i   (md_valid_i),
        .md_idx_i     (md_idx_i),
        .md_data_i    (md_data_i),
        .md_ready_o   (md_ready_o),
        .pipe_stall_o (pipe_stall_o),
        .rf_wen_o     (rf_wen_o),
        .rf_idx_o     (rf_idx_o),
        .rf_data_o    (rf_data_o),
        .hold_valid_o (hold_valid_o),
        .hold_idx_o   (hold_idx_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a parked result (if any), how many busy cycles it has
    // waited, and whether the coming cycle is its forced retirement.
    bit            m_hv, m_force;
    logic [IW-1:0] m_hidx;
    logic [DW-1:0] m_hdata;
    int            m_waited;
    bit            md_taken;
    bit            prev_stall;

    initial begin
        m_hv = 0; m_force = 0; m_hidx = '0; m_hdata = '0; m_waited = 0;
        md_taken = 0; prev_stall = 0;
    end

    always @(negedge clk) begin : cmp
        bit            busy, e_rdy, e_stall, e_wen, e_hv;
        logic [IW-1:0] e_idx, e_hidx;
        logic [DW-1:0] e_data;
        busy    = pipe_wen_i && (pipe_idx_i != 0);
        e_rdy   = 0; e_stall = 0; e_wen = 0; e_idx = '0; e_data = '0;
        e_hv    = 0; e_hidx  = '0;
        md_taken = 0;
        if (rst) begin
            m_hv = 0; m_force = 0;
        end else begin
            e_hv = m_hv; e_hidx = m_hidx;
            e_wen = busy; e_idx = pipe_idx_i; e_data = pipe_data_i;
            if (!m_hv) begin
                e_rdy = 1;
                if (md_valid_i) begin
                    md_taken = 1;
                    if (md_idx_i == 0) begin
                    end else if (!busy) begin
                        e_wen = 1; e_idx = md_idx_i; e_data = md_data_i;
                    end else if (pipe_idx_i != md_idx_i) begin
                        m_hv = 1; m_hidx = md_idx_i; m_hdata = md_data_i; m_waited = 0;
                    end
                end
            end else if (m_force) begin
                e_stall = 1; e_wen = 1; e_idx = m_hidx; e_data = m_hdata;
                m_hv = 0; m_force = 0;
            end else if (busy && pipe_idx_i == m_hidx) begin
                m_hv = 0;
            end else if (!busy) begin
                e_wen = 1; e_idx = m_hidx; e_data = m_hdata;
                m_hv = 0;
            end else begin
                m_waited++;
                if (m_waited == MW) m_force = 1;
            end
        end
        chk("md_ready", md_ready_o, e_rdy);
        chk("pipe_stall", pipe_stall_o, e_stall);
        chk("rf_wen", rf_wen_o, e_wen);
        chk("rf_idx", rf_idx_o, e_idx);
        chk("rf_data", rf_data_o, e_data);
        chk("hold_valid", hold_valid_o, e_hv);
        if (e_hv || rst) chk("hold_idx", hold_idx_o, e_hidx);
        chk("stall_back_to_back", prev_stall && pipe_stall_o, 1'b0);
        prev_stall = pipe_stall_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wen_i = 0; pipe_idx_i = '0; pipe_data_i = '0;
        md_valid_i = 0; md_idx_i = '0; md_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle();
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; idle();
        tick(); tick();
        rst = 0;

        // Bypass in EMPTY with a free slot.
        md_valid_i = 1; md_idx_i = 5; md_data_i = 32'hDEAD;
        #2;
        chk("t1_wen", rf_wen_o, 1'b1);
        chk("t1_idx", rf_idx_o, 5);
        chk("t1_data", rf_data_o, 32'hDEAD);
        chk("t1_ready", md_ready_o, 1'b1);
        tick(); idle(); #2;
        chk("t1_ready_after", md_ready_o, 1'b1);
        chk("t1_hold_after", hold_valid_o, 1'b0);

        // Forced drain after MAX_WAIT busy cycles.
        tick();
        pipe_wen_i = 1; pipe_idx_i = 3; pipe_data_i = 32'h33;
        md_valid_i = 1; md_idx_i = 7; md_data_i = 32'h77;
        #2;
        chk("t2_c0_idx", rf_idx_o, 3);
        tick(); md_valid_i = 0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk("t2_hold_valid", hold_valid_o, 1'b1);
            chk("t2_hold_idx", hold_idx_o, 7);
            chk("t2_pipe_idx", rf_idx_o, 3);
            chk("t2_no_stall", pipe_stall_o, 1'b0);
            tick();
        end
        #2;
        chk("t2_c5_stall", pipe_stall_o, 1'b1);
        chk("t2_c5_idx", rf_idx_o, 7);
        chk("t2_c5_data", rf_data_o, 32'h77);
        tick(); #2;
        chk("t2_c6_ready", md_ready_o, 1'b1);
        chk("t2_c6_stall", pipe_stall_o, 1'b0);
        chk("t2_c6_hold", hold_valid_o, 1'b0);

        // WAW: younger pipe write kills the held result.
        tick();
        pipe_wen_i = 1; pipe_idx_i = 3; pipe_data_i = 32'h1234;
        md_valid_i = 1; md_idx_i = 9; md_data_i = 32'h99;
        tick(); md_valid_i = 0;
        pipe_idx_i = 9; pipe_data_i = 32'h1;
        #2;
        chk("t3_wen", rf_wen_o, 1'b1);
        chk("t3_idx", rf_idx_o, 9);
        chk("t3_data", rf_data_o, 32'h1);
        tick(); pipe_wen_i = 0; #2;
        chk("t3_hold_cleared", hold_valid_o, 1'b0);
        chk("t3_no_md_write", rf_wen_o, 1'b0);

        // Same-cycle same index, then md to x0.
        tick();
        pipe_wen_i = 1; pipe_idx_i = 4; pipe_data_i = 32'hBB;
        md_valid_i = 1; md_idx_i = 4; md_data_i = 32'hAA;
        #2;
        chk("t4_data", rf_data_o, 32'hBB);
        chk("t4_idx", rf_idx_o, 4);
        tick(); idle(); #2;
        chk("t4_no_capture", hold_valid_o, 1'b0);
        tick();
        md_valid_i = 1; md_idx_i = 0; md_data_i = 32'h55;
        #2;
        chk("t4_x0_wen", rf_wen_o, 1'b0);
        tick(); idle(); #2;
        chk("t4_x0_no_capture", hold_valid_o, 1'b0);
        chk("t4_x0_ready", md_ready_o, 1'b1);

        // Reset while a result is held.
        tick();
        pipe_wen_i = 1; pipe_idx_i = 3; pipe_data_i = 32'h5;
        md_valid_i = 1; md_idx_i = 12; md_data_i = 32'hC;
        tick(); md_valid_i = 0; rst = 1; pipe_wen_i = 0;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("t5_rst_ready", md_ready_o, 1'b0);
            chk("t5_rst_wen", rf_wen_o, 1'b0);
            chk("t5_rst_hold", hold_valid_o, 1'b0);
            chk("t5_rst_idx", rf_idx_o, 0);
            tick();
        end
        rst = 0; #2;
        chk("t5_ready_after", md_ready_o, 1'b1);
        chk("t5_no_write12", rf_wen_o, 1'b0);
        chk("t5_hold_after", hold_valid_o, 1'b0);

        // Randomized traffic; mul/div holds its request until taken.
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (md_taken) md_valid_i = 0;
            if (!md_valid_i && ($urandom_range(0, 2) == 0)) begin
                md_valid_i = 1;
                md_idx_i   = IW'($urandom_range(0, 7));
                md_data_i  = $urandom;
            end
            pipe_wen_i  = ($urandom_range(0, 9) < 7);
            pipe_idx_i  = IW'($urandom_range(0, 7));
            pipe_data_i = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            if (rst) md_valid_i = 0;
        end
        rst = 0; idle();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
